// File: rtl/lfsr_rand_gen.sv
// Fibonacci-LFSR random source with prescaled free-run stepping, runtime seed load
// and a req/valid port returning unbiased bounded draws by rejection sampling.
module lfsr_rand_gen #(
  parameter int                 WIDTH      = 8,
  parameter logic [WIDTH-1:0]   TAPS       = 8'hB8,
  parameter logic [WIDTH-1:0]   RESET_SEED = 8'd200,
  parameter int                 STEP_DIV   = 2,
  parameter int                 OUT_W      = 8,
  parameter int                 MAX_TRIES  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] range,
  output logic [WIDTH-1:0] rand_num,
  output logic             rsp_valid,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_fallback,
  output logic             busy,
  output logic             seed_zero
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {
    IDLE,
    DRAW
  } fsm_t;

  fsm_t             fsm;
  fsm_t             fsm_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [TRY_W-1:0] try_cnt;
  logic [OUT_W-1:0] range_q;
  logic [OUT_W-1:0] mask_q;
  logic [OUT_W-1:0] cand;
  logic             in_range;
  logic             last_try;
  logic             start;
  logic             accept;
  logic             take_fallback;

  // One shift of the register; a zero result is replaced so the LFSR can never lock up.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = {s[WIDTH-2:0], ^(s & TAPS)};
    return (n == '0) ? RESET_SEED : n;
  endfunction

  // Smallest all-ones mask covering range-1; range=0 wraps to all ones.
  function automatic logic [OUT_W-1:0] range_mask(input logic [OUT_W-1:0] r);
    logic [OUT_W-1:0] v;
    logic [OUT_W-1:0] m;
    v = r - OUT_W'(1);
    m = v;
    for (int i = 1; i < OUT_W; i++) begin
      m = m | (v >> i);
    end
    return m;
  endfunction

  assign cand     = rand_num[OUT_W-1:0] & mask_q;
  assign in_range = (range_q == '0) || (cand < range_q);
  assign last_try = (try_cnt == TRY_LAST);
  assign busy     = (fsm != IDLE);

  always_comb begin
    fsm_nxt       = fsm;
    start         = 1'b0;
    accept        = 1'b0;
    take_fallback = 1'b0;
    if (load) begin
      fsm_nxt = IDLE;
    end else begin
      case (fsm)
        IDLE: begin
          if (req) begin
            start   = 1'b1;
            fsm_nxt = DRAW;
          end
        end
        DRAW: begin
          if (in_range) begin
            accept  = 1'b1;
            fsm_nxt = IDLE;
          end else if (last_try) begin
            accept        = 1'b1;
            take_fallback = 1'b1;
            fsm_nxt       = IDLE;
          end
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // LFSR state, prescaler and sticky zero-seed flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rand_num  <= RESET_SEED;
      div_cnt   <= '0;
      seed_zero <= 1'b0;
    end else if (load) begin
      div_cnt <= '0;
      if (seed == '0) begin
        rand_num  <= RESET_SEED;
        seed_zero <= 1'b1;
      end else begin
        rand_num <= seed;
      end
    end else if (fsm == DRAW) begin
      rand_num <= lfsr_step(rand_num);
    end else if (en) begin
      if (div_cnt == DIV_LAST) begin
        rand_num <= lfsr_step(rand_num);
        div_cnt  <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Draw bookkeeping and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      try_cnt      <= '0;
      range_q      <= '0;
      mask_q       <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_fallback <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (load || start) begin
        try_cnt <= '0;
      end else if ((fsm == DRAW) && !accept) begin
        try_cnt <= try_cnt + TRY_W'(1);
      end
      if (start) begin
        range_q <= range;
        mask_q  <= range_mask(range);
      end
      if (accept) begin
        rsp_data     <= take_fallback ? (cand - range_q) : cand;
        rsp_fallback <= take_fallback;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: instance a uses default parameters,
// instance b runs STEP_DIV=1 / MAX_TRIES=1 for period and fallback vectors.
module tb_lfsr_rand_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_a, load_a, req_a;
  logic [7:0] seed_a, range_a;
  logic [7:0] rand_num_a, rsp_data_a;
  logic       rsp_valid_a, rsp_fallback_a, busy_a, seed_zero_a;

  logic       en_b, load_b, req_b;
  logic [7:0] seed_b, range_b;
  logic [7:0] rand_num_b, rsp_data_b;
  logic       rsp_valid_b, rsp_fallback_b, busy_b, seed_zero_b;

  int checks = 0;
  int failures = 0;

  lfsr_rand_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a), .seed(seed_a),
    .req(req_a), .range(range_a), .rand_num(rand_num_a), .rsp_valid(rsp_valid_a),
    .rsp_data(rsp_data_a), .rsp_fallback(rsp_fallback_a), .busy(busy_a),
    .seed_zero(seed_zero_a)
  );

  lfsr_rand_gen #(.STEP_DIV(1), .MAX_TRIES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b), .seed(seed_b),
    .req(req_b), .range(range_b), .rand_num(rand_num_b), .rsp_valid(rsp_valid_b),
    .rsp_data(rsp_data_b), .rsp_fallback(rsp_fallback_b), .busy(busy_b),
    .seed_zero(seed_zero_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance a and wait (bounded) for its response.
  task automatic draw_a(input logic [7:0] r, output logic [7:0] data,
                        output logic fb, output int n);
    req_a   = 1'b1;
    range_a = r;
    tick();
    req_a = 1'b0;
    chk("draw_busy", busy_a, 1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rsp_valid_a) begin
        n = i;
        break;
      end
    end
    data = rsp_data_a;
    fb   = rsp_fallback_a;
  endtask

  logic [7:0] d;
  logic       f;
  int         n;
  int         zeros;
  int         early;
  int         pulses;

  initial begin
    en_a = 0; load_a = 0; req_a = 0; seed_a = 0; range_a = 0;
    en_b = 0; load_b = 0; req_b = 0; seed_b = 0; range_b = 0;
    repeat (2) tick();
    chk("rst_rand_a", rand_num_a, 8'hC8);
    chk("rst_rand_b", rand_num_b, 8'hC8);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", rsp_valid_a, 0);
    chk("rst_data", rsp_data_a, 0);
    chk("rst_fb", rsp_fallback_a, 0);
    chk("rst_szero", seed_zero_a, 0);

    // Prescaled free run then freeze
    rst_n = 1'b1;
    en_a  = 1'b1;
    tick();
    chk("div_hold", rand_num_a, 8'hC8);
    tick();
    chk("step1", rand_num_a, 8'h90);
    tick();
    tick();
    chk("step2", rand_num_a, 8'h20);
    en_a = 1'b0;
    repeat (10) tick();
    chk("en_freeze", rand_num_a, 8'h20);

    // Full period on instance b
    en_b  = 1'b1;
    zeros = 0;
    early = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (rand_num_b == 8'h00) zeros++;
      if (i < 255 && rand_num_b == 8'hC8) early++;
    end
    en_b = 1'b0;
    chk("period_end", rand_num_b, 8'hC8);
    chk("period_zero", zeros, 0);
    chk("period_early", early, 0);

    // Fallback with MAX_TRIES=1
    req_b   = 1'b1;
    range_b = 8'd129;
    tick();
    req_b = 1'b0;
    chk("fb_busy", busy_b, 1);
    chk("fb_nvalid", rsp_valid_b, 0);
    tick();
    chk("fb_valid", rsp_valid_b, 1);
    chk("fb_data", rsp_data_b, 8'd71);
    chk("fb_flag", rsp_fallback_b, 1);
    chk("fb_idle", busy_b, 0);
    tick();
    chk("fb_pulse", rsp_valid_b, 0);

    // Bounded draws after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    draw_a(8'd200, d, f, n);
    chk("r200_data", d, 8'd144);
    chk("r200_fb", f, 0);
    chk("r200_lat", n, 2);
    draw_a(8'd0, d, f, n);
    chk("r0_data", d, 8'h20);
    chk("r0_lat", n, 1);
    tick();
    chk("r0_pulse", rsp_valid_a, 0);
    chk("r0_hold", rsp_data_a, 8'h20);
    draw_a(8'd1, d, f, n);
    chk("r1_data", d, 8'd0);
    chk("r1_fb", f, 0);
    chk("r1_lat", n, 1);

    // Seed loads
    load_a = 1'b1;
    seed_a = 8'h00;
    tick();
    load_a = 1'b0;
    chk("ld0_rand", rand_num_a, 8'hC8);
    chk("ld0_szero", seed_zero_a, 1);
    load_a = 1'b1;
    seed_a = 8'h5A;
    tick();
    load_a = 1'b0;
    chk("ld5a_rand", rand_num_a, 8'h5A);
    chk("ld5a_szero", seed_zero_a, 1);

    // Load aborts a draw in progress
    req_a   = 1'b1;
    range_a = 8'd200;
    tick();
    req_a  = 1'b0;
    chk("abort_busy", busy_a, 1);
    load_a = 1'b1;
    seed_a = 8'h33;
    tick();
    load_a = 1'b0;
    chk("abort_idle", busy_a, 0);
    chk("abort_nvalid", rsp_valid_a, 0);
    chk("abort_rand", rand_num_a, 8'h33);
    pulses = 0;
    repeat (5) begin
      tick();
      if (rsp_valid_a) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_hold", rand_num_a, 8'h33);

    // Request held during DRAW is not queued
    load_a = 1'b1;
    seed_a = 8'hC8;
    tick();
    load_a  = 1'b0;
    req_a   = 1'b1;
    range_a = 8'd200;
    tick();
    tick();
    req_a = 1'b0;
    chk("hold_nvalid", rsp_valid_a, 0);
    pulses = 0;
    d = 8'h00;
    repeat (8) begin
      tick();
      if (rsp_valid_a) begin
        pulses++;
        d = rsp_data_a;
      end
    end
    chk("single_pulse", pulses, 1);
    chk("single_data", d, 8'd144);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
Parametrised Fibonacci-LFSR pseudo-random source for the game/display logic, with these features:
- configurable width, taps and reset seed;
- step prescaler, enable, and runtime seed load;
- zero-lock-up protection.

Adds a req/valid draw port that returns an unbiased value in [0, range) by rejection sampling, with a bounded-retry fallback. Consumers are sprite/obstacle placement logic that need bounded coordinates.

Parameters:
WIDTH, 8, LFSR state width (>=3)
TAPS, 8'hB8, feedback mask; bit i set => state[i] XORed into feedback (default maximal, period 255)
RESET_SEED, 200, state after reset and substitute for zero seeds; must be nonzero
STEP_DIV, 2, free-run step period in clk cycles (>=1)
OUT_W, 8, draw width (<= WIDTH)
MAX_TRIES, 16, rejected draws before fallback (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  free-run stepping enable
load  in  1  load seed (active high, single cycle)
seed  in  WIDTH  seed value
req  in  1  draw request
range  in  OUT_W  exclusive upper bound; 0 = full 2^OUT_W range
rand_num  out  WIDTH  current LFSR state
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_data  out  OUT_W  bounded random result
rsp_fallback  out  1  valid with rsp_valid; result came from fallback path
busy  out  1  draw in progress (FSM != IDLE)
seed_zero  out  1  sticky: a zero seed was substituted

Behaviour:
- Reset (async, rst_n low): state=RESET_SEED, div_cnt=0, FSM=IDLE, rsp_valid=0, rsp_data=0, rsp_fallback=0, busy=0, seed_zero=0, try_cnt=0.
- Step function: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}. rand_num = state, registered, no extra latency.
- Prescaler: only in IDLE with en=1, div_cnt counts 0..STEP_DIV-1; step when div_cnt==STEP_DIV-1, then div_cnt=0. en=0 freezes div_cnt and state. STEP_DIV=1 steps every enabled cycle.
- Load (highest priority, any FSM state):
  - state=seed, div_cnt=0.
  - If seed==0: state=RESET_SEED and seed_zero set (cleared only by reset).
  - Aborts any draw: FSM->IDLE, no rsp_valid, try_cnt=0.
- Lock-up guard: state is never zero; any path producing zero substitutes RESET_SEED.
- Mask: smallest all-ones mask m >= range-1 (range=1 -> m=0; range=0 -> m=all ones).
- FSM IDLE:
  - req=1 and load=0: latch range, compute m, try_cnt=0, ->DRAW.
  - The prescaler step due in that same cycle still occurs.
  - req while busy is ignored, not queued.
- FSM DRAW (one cycle per try; prescaler and en are ignored):
  - cand = state[OUT_W-1:0] & m.
  - Every DRAW cycle steps the LFSR once, at the end of the cycle.
  - range==0 or cand<range: accept, rsp_data=cand, rsp_fallback=0.
  - Else if try_cnt==MAX_TRIES-1: accept, rsp_data=cand-range (always < range since m < 2*range), rsp_fallback=1.
  - Else: try_cnt++, stay in DRAW.
  - On accept: next cycle rsp_valid=1 for exactly one cycle, FSM=IDLE, busy=0.
- Latency: req sampled at edge k -> rsp_valid high in cycle k+1+n, where n = number of draws (1..MAX_TRIES). busy is high from cycle k+1 through the accepting DRAW cycle.
- rsp_data and rsp_fallback hold until the next accept.

Test Plan:
1. Reset, en=1, STEP_DIV=2 -> rand_num=0xC8 (8'd200), then 0x90 after 2 cycles, then 0x20 after 2 more; with en=0, no change for 10 cycles.
2. Free-run 255 steps from 0xC8 (STEP_DIV=1) -> returns to 0xC8, never 0x00, no earlier repeat.
3. load=1, seed=0x00 -> rand_num=0xC8, seed_zero=1; then load seed=0x5A -> rand_num=0x5A, seed_zero stays 1.
4. After reset, en=0, req with range=200 -> cand 200 rejected, then 0x90 accepted: rsp_data=144, rsp_fallback=0, rsp_valid 3 cycles after req edge. range=0 -> rsp_data=current state; range=1 -> rsp_data=0 after 1 draw.
5. MAX_TRIES=1, state=0xC8, range=129 (m=0xFF) -> cand 200 rejected, fallback rsp_data=71, rsp_fallback=1.
6. load asserted while busy -> no rsp_valid, busy=0 next cycle, rand_num=seed; req asserted during DRAW -> ignored, single response.
